digit_scan_driver: RTL



---
 rtl/disp_pkg.sv | 33 +++
 rtl/digit_scan_driver_if.sv | 20 ++
 rtl/scan_onehot_dec.sv | 14 +
 rtl/digit_scan_driver.sv | 129 ++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display-block types and helpers: scan FSM states, index sizing,
// active-low one-hot and nibble extraction.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK, MANUAL} state_t;

  localparam int MAX_DIGITS = 32;
  localparam int MAX_SEL_W  = 5;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [MAX_SEL_W-1:0] idx,
                                                       input logic en);
    logic [MAX_DIGITS-1:0] v;
    v = '1;
    if (en) v[idx] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*MAX_DIGITS-1:0] v,
                                           input logic [MAX_SEL_W-1:0] idx);
    return v[4*idx +: 4];
  endfunction

endpackage

// File: rtl/digit_scan_driver_if.sv
// Display-side bundle: control/data towards the scan driver, anode/nibble back.
interface digit_scan_driver_if #(parameter int N_DIGITS = 4);
  import disp_pkg::*;
  localparam int SEL_W = sel_width(N_DIGITS);

  logic                  en;
  logic                  auto;
  logic [SEL_W-1:0]      sel;
  logic [N_DIGITS-1:0]   digit_mask;
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   anode_n;
  logic [3:0]            digit_out;
  logic [SEL_W-1:0]      cur_idx;
  logic                  frame_tick;

  modport master (output en, auto, sel, digit_mask, digits_in,
                  input  anode_n, digit_out, cur_idx, frame_tick);
  modport slave  (input  en, auto, sel, digit_mask, digits_in,
                  output anode_n, digit_out, cur_idx, frame_tick);
endinterface

// File: rtl/scan_onehot_dec.sv
// N-output active-low decoder; an out-of-range index matches no output and
// therefore leaves every output high.
module scan_onehot_dec #(
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [N_OUT-1:0] dec_n
);
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign dec_n[i] = ~(en && (idx == SEL_W'(i)));
  end
endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed N-digit anode driver: auto scan with dwell and blanking,
// per-digit mask, manual select and frame tick. All outputs are registered.
module digit_scan_driver
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL        = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  digit_scan_driver_if.slave bus
);
  localparam int SEL_W = sel_width(N_DIGITS);
  localparam int CNT_W = $clog2(max3(DWELL, BLANK_CYCLES, 2));
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N_DIGITS - 1);

  state_t              state, nstate;
  logic [SEL_W-1:0]    idx, nidx, out_idx, idx_inc;
  logic [CNT_W-1:0]    cnt, ncnt;
  logic                ntick;
  logic                sel_ok, dec_en;
  logic [N_DIGITS-1:0] dec_n;
  logic [3:0]          ndigit;
  logic [MAX_SEL_W-1:0]    nib_idx;
  logic [4*MAX_DIGITS-1:0] digits_ext;

  logic [N_DIGITS-1:0] anode_r;
  logic [3:0]          digit_r;
  logic [SEL_W-1:0]    cur_r;
  logic                tick_r;

  assign idx_inc = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign sel_ok  = (int'(bus.sel) < N_DIGITS);

  always_comb begin
    nstate = state;
    nidx   = idx;
    ncnt   = cnt;
    ntick  = 1'b0;
    if (!bus.en) begin
      nstate = IDLE;
      nidx   = '0;
      ncnt   = '0;
    end else if (!bus.auto) begin
      nstate = MANUAL;
      ncnt   = '0;
    end else begin
      case (state)
        IDLE, MANUAL: begin
          nstate = SHOW;
          nidx   = '0;
          ncnt   = '0;
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            ncnt = '0;
            if (BLANK_CYCLES > 0) begin
              nstate = BLANK;
            end else begin
              nidx  = idx_inc;
              ntick = (idx == LAST_IDX);
            end
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            nstate = SHOW;
            nidx   = idx_inc;
            ncnt   = '0;
            ntick  = (idx == LAST_IDX);
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land together with it.
  always_comb begin
    out_idx = (nstate == MANUAL) ? bus.sel : nidx;
    dec_en  = ((nstate == SHOW) && bus.digit_mask[nidx]) ||
              ((nstate == MANUAL) && sel_ok && bus.digit_mask[bus.sel]);
    digits_ext = '0;
    digits_ext[4*N_DIGITS-1:0] = bus.digits_in;
    nib_idx = '0;
    nib_idx[SEL_W-1:0] = out_idx;
    ndigit = '0;
    if ((nstate == SHOW) || ((nstate == MANUAL) && sel_ok))
      ndigit = nibble_at(digits_ext, nib_idx);
  end

  scan_onehot_dec #(.N_OUT(N_DIGITS), .SEL_W(SEL_W)) u_dec (
    .idx   (out_idx),
    .en    (dec_en),
    .dec_n (dec_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      anode_r <= '1;
      digit_r <= '0;
      cur_r   <= '0;
      tick_r  <= 1'b0;
    end else begin
      state   <= nstate;
      idx     <= nidx;
      cnt     <= ncnt;
      anode_r <= dec_n;
      digit_r <= ndigit;
      cur_r   <= out_idx;
      tick_r  <= ntick;
    end
  end

  assign bus.anode_n    = anode_r;
  assign bus.digit_out  = digit_r;
  assign bus.cur_idx    = cur_r;
  assign bus.frame_tick = tick_r;
endmodule
